ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-requester arbiter in front of the byte-wide system RAM. Port 0 is the CPU bus unit; port 1 is the loader/DMA.
//  Grants at most one access per cycle to the RAM's write or read port, with round-robin fairness.
//  A lock lets one owner finish a multi-byte transfer (e.g. an 8086 word = 2 bytes) back-to-back.
//  Routes the RAM's 1-cycle-latency read data back to the requester that issued the read.
// PARAMETERS
//  ADDR_W   11  address width, matches the RAM add_size
//  DATA_W   8   data width, matches the RAM data_size
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  pN_req         in   1       N=0,1: access request, held until granted
//  pN_we          in   1       1 = write, 0 = read; valid with pN_req
//  pN_addr        in   ADDR_W  byte address
//  pN_wdata       in   DATA_W  write data
//  pN_lock        in   1       keep ownership after this access
//  pN_gnt         out  1       access accepted this cycle (combinational)
//  pN_rvalid      out  1       read data valid on pN_rdata
//  pN_rdata       out  DATA_W  read data (broadcast from RAM)
//  ram_write_en   out  1       to RAM
//  ram_write_addr out  ADDR_W  to RAM
//  ram_data_in    out  DATA_W  to RAM
//  ram_rd_en      out  1       to RAM
//  ram_rd_addr    out  ADDR_W  to RAM
//  ram_data_out   in   DATA_W  from RAM; registered, 1-cycle read latency
// BEHAVIOUR
//  - State: owner (1b, last granted port), locked (1b), rd_pend (1b), rd_tag (1b).
//  - FSM: IDLE (!locked) and LOCKED_N (locked, owner=N).
//    IDLE -> LOCKED_N when port N is granted with pN_lock=1.
//    LOCKED_N -> IDLE on the first granted pN access with pN_lock=0.
//  - Grant in IDLE:
//    * only one port requesting -> that port;
//    * both requesting -> the port != owner (round-robin);
//    * owner <= granted port.
//  - Grant in LOCKED_N: only port N may be granted; the other port's req is held off with gnt=0.
//    If pN_req=0 the RAM idles; the lock persists.
//  - A transfer happens on a cycle with pN_req & pN_gnt. In that cycle the RAM strobes are driven
//    combinationally from port N:
//    * write: ram_write_en=1, with addr and data;
//    * read: ram_rd_en=1, with addr.
//    When no grant, both enables are 0; addresses and data are don't-care but driven from port 0.
//  - Never asserts ram_write_en and ram_rd_en in the same cycle.
//  - Read granted at cycle T: rd_pend=1 and rd_tag=N registered at T. pN_rvalid=1 in cycle T+1
//    (rd_pend & rd_tag==N), with pN_rdata = ram_data_out.
//    Back-to-back reads give one rvalid per cycle with no bubble.
//  - A write acknowledges only by gnt; there is no rvalid for writes.
//  - Read at T+1 of an address written at T returns the new data (the RAM updates at T).
//  - Reset values: owner=1 (port 0 wins the first tie), locked=0, rd_pend=0, all rvalid=0.
//    Combinational outputs follow the reset state.
//  - While rst=1: no grants, both RAM enables 0.
//  - Reset mid-operation: pending read dropped (no rvalid after reset); lock released.
//  - Requester rules: req must stay high with stable we/addr/wdata until gnt. Dropping req before
//    gnt is legal and has no effect.
// STRUCTURE
//  - Shared package ram_pkg: ADDR_W/DATA_W defaults, port index constants PORT_CPU=0 and PORT_DMA=1,
//    and FSM state encodings ST_IDLE/ST_LOCKED.
//  - One sub-module, rr_pick2: 2-way round-robin select (req[1:0], last -> gnt[1:0]), purely
//    combinational. The remaining logic is flat in ram_arbiter.
// TESTING (bench instantiates ram_arbiter + ram, ADDR_W=11, DATA_W=8)
//  1. p0 write addr 0x010=0xA5; next cycle p0 read 0x010
//     -> p0_gnt both cycles, p0_rvalid 1 cycle after the read grant, p0_rdata=0xA5.
//  2. p0 and p1 reqs both held for 4 cycles, all reads
//     -> grants alternate p0,p1,p0,p1 starting with p0 after reset; each rvalid goes to the matching port only.
//  3. p1 lock=1 write 0x100=0x34, then lock=0 write 0x101=0x12, with p0 req held throughout
//     -> p1 granted 2 consecutive cycles, p0_gnt=0 until the cycle after p1's unlocked write, then p0 granted.
//  4. p0 read 0x7FF at T, rst pulsed at T+1
//     -> p0_rvalid never asserted, both RAM enables 0 during reset, next tie grants p0.
//  5. Write then read same address on alternate ports (p1 write 0x055=0x3C, p0 read 0x055 next cycle)
//     -> p0_rdata=0x3C.
//  6. Random 10k-cycle traffic with lock
//     -> scoreboard vs reference memory; assertions: RAM enables mutually exclusive, at most 1 gnt per cycle,
//        no starvation beyond 2 cycles when unlocked.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the system RAM arbiter: default widths, port
// indices and the lock FSM encoding.
package ram_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;

  // Requester indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Lock FSM encodings (owner of a lock is held separately)
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Index of the granted port from a one-hot (or zero) grant vector.
  // A zero vector maps to port 0 so idle RAM buses follow the CPU port.
  function automatic logic gnt_index(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: with both requesting, the port that was not
// granted last wins; a lone requester always wins. Purely combinational.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Select one requester, favouring the port that did not win last time
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b00:   gnt = 2'b00;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the byte-wide system RAM. Port 0 is the
// CPU bus unit, port 1 the loader/DMA. One access per cycle, round-robin on
// ties, an optional lock for back-to-back multi-byte transfers, and routing
// of the RAM's 1-cycle read data back to the port that issued the read.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic              state;     // ST_IDLE or ST_LOCKED
  logic              owner;     // last granted port, also the lock holder
  logic              rd_pend;   // a read was granted last cycle
  logic              rd_tag;    // port that issued that read

  logic [1:0]        req;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {p1_req, p0_req};

  rr_pick2 u_pick (
    .req  (req),
    .last (owner),
    .gnt  (rr_gnt)
  );

  // Grant: nothing during reset, only the lock holder while locked,
  // otherwise the round-robin choice
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (state == ST_LOCKED) begin
      if (owner == PORT_DMA) begin
        gnt = {p1_req, 1'b0};
      end else begin
        gnt = {1'b0, p0_req};
      end
    end else begin
      gnt = rr_gnt;
    end
  end

  assign any_gnt = gnt[1] | gnt[0];
  assign sel     = gnt_index(gnt);
  assign p0_gnt  = gnt[0];
  assign p1_gnt  = gnt[1];

  // Route the selected port's request fields toward the RAM (port 0 when idle)
  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (sel == PORT_DMA) begin
      sel_we    = p1_we;
      sel_lock  = p1_lock;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else begin
      sel_we    = p0_we;
      sel_lock  = p0_lock;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
  end

  // Strobes are mutually exclusive because a single grant selects one direction
  assign ram_write_en   = any_gnt & sel_we;
  assign ram_rd_en      = any_gnt & ~sel_we;
  assign ram_write_addr = sel_addr;
  assign ram_rd_addr    = sel_addr;
  assign ram_data_in    = sel_wdata;

  // Ownership, lock state and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= PORT_DMA;
      rd_pend <= 1'b0;
      rd_tag  <= PORT_CPU;
    end else begin
      if (any_gnt) begin
        owner <= sel;
        state <= sel_lock ? ST_LOCKED : ST_IDLE;
      end
      rd_pend <= any_gnt & ~sel_we;
      if (any_gnt & ~sel_we) begin
        rd_tag <= sel;
      end
    end
  end

  // Read data is broadcast; rvalid steers it, and is suppressed during reset
  // so a read in flight when reset hits is dropped
  assign p0_rvalid = ~rst & rd_pend & (rd_tag == PORT_CPU);
  assign p1_rvalid = ~rst & rd_pend & (rd_tag == PORT_DMA);
  assign p0_rdata  = ram_data_out;
  assign p1_rdata  = ram_data_out;

endmodule
